lcd_hex_display: RTL and testbench
==================================

Name: lcd_hex_display

Overview:
- Downstream consumer of the PCIe system's 32-bit display PIO export.
- Initialises the board's HD44780-compatible 16x2 character LCD in 8-bit mode.
- Continuously renders the 32-bit value as 8 upper-case hex ASCII characters at line 1, columns 0-7.
- Re-renders only when the value changes. Write-only LCD access; no busy-flag polling, all timing by cycle counters.

Parameters:
- POWERUP_CYCLES, 750000, wait after reset before first command (15 ms at 50 MHz).
- EN_PULSE_CYCLES, 25, lcd_en high time per write (500 ns).
- CMD_WAIT_CYCLES, 2500, post-write wait for normal commands/data (50 us).
- CLEAR_WAIT_CYCLES, 100000, post-write wait after clear command 0x01 (2 ms).

Ports:
- clk  input  1  system clock (same domain as the PIO).
- reset_n  input  1  asynchronous active-low reset.
- display_value  input  32  value to show; from the display PIO export.
- lcd_data  output  8  LCD DB7..DB0.
- lcd_rs  output  1  0 = command, 1 = data.
- lcd_rw  output  1  always 0 (write).
- lcd_en  output  1  LCD enable strobe.
- lcd_on  output  1  LCD power, constant 1.
- lcd_blon  output  1  backlight, constant 1.
- busy  output  1  high during init or any frame in progress.

Behaviour:
- Reset: async assert, sync release. lcd_data=0x00, lcd_rs=0, lcd_rw=0, lcd_en=0, lcd_on=1, lcd_blon=1, busy=1. All counters 0; shadow register 0x00000000.
- Reset mid-write: lcd_en drops to 0 immediately; the init sequence restarts from POWERUP.
- States: POWERUP, INIT, FRAME, IDLE. A write sub-sequencer is used by INIT and FRAME.
- Write sub-sequence, one write = SETUP (1 cycle) -> PULSE (EN_PULSE_CYCLES) -> WAIT (0x01: CLEAR_WAIT_CYCLES; else CMD_WAIT_CYCLES).
  - SETUP: lcd_data/lcd_rs driven, lcd_en=0.
  - PULSE: lcd_en=1.
  - WAIT: lcd_en=0.
  - lcd_data/lcd_rs stay stable from SETUP through the end of WAIT.
- POWERUP: count POWERUP_CYCLES with lcd_en=0, then go to INIT.
- INIT: issue commands in order, all lcd_rs=0: 0x38, 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06. Then go to FRAME.
- FRAME:
  - First cycle of FRAME: latch display_value into shadow.
  - Write command 0x80 (lcd_rs=0).
  - Then 8 data writes (lcd_rs=1), nibbles shadow[31:28] down to shadow[3:0].
  - Nibble encoding: 0-9 -> 0x30-0x39; A-F -> 0x41-0x46.
  - After the 8th write's WAIT completes, go to IDLE.
- IDLE: busy=0, lcd_en=0, lcd_data/lcd_rs hold their last values. Each cycle, display_value is compared with shadow; on inequality go to FRAME next cycle.
- Changes to display_value during FRAME do not disturb the frame in progress. The new value is picked up at the IDLE compare, so the final frame always matches the latest stable value.
- busy: 1 in POWERUP/INIT/FRAME, 0 only in IDLE.
- Frame length: 9 writes, 9*(1+EN_PULSE_CYCLES+CMD_WAIT_CYCLES) cycles.
- Init length: POWERUP_CYCLES + 6*(1+EN_PULSE_CYCLES+CMD_WAIT_CYCLES) + (1+EN_PULSE_CYCLES+CLEAR_WAIT_CYCLES) cycles.
- lcd_en never high for more than EN_PULSE_CYCLES consecutive cycles. It is never high in consecutive writes without an intervening WAIT.
- display_value is assumed synchronous to clk; no internal synchroniser.

Test Plan:
- Sim params for all tests: POWERUP=10, EN=2, CMD_WAIT=4, CLEAR_WAIT=8.
- Reset release, display_value=0 -> lcd_en=0 for 10 cycles; then 7 commands 0x38,0x38,0x38,0x38,0x0C,0x01,0x06 with rs=0. Each en-high for exactly 2 cycles; the 0x01 write is followed by 8 low cycles. Then 0x80 and eight 0x30 with rs=1; busy falls after the frame (init 10+6*7+11=63 cycles, frame 63 cycles).
- In IDLE, set display_value=0x1234ABCF -> busy rises next cycle; a single frame writes 0x80, then 0x31,0x32,0x33,0x34,0x41,0x42,0x43,0x46; busy=0 afterwards.
- Hold display_value constant in IDLE for 500 cycles -> no lcd_en pulses, busy stays 0.
- Change display_value 0x00000000 -> 0xFFFFFFFF in the middle of the 3rd data write -> the current frame completes with eight 0x30. A second frame immediately follows with eight 0x46; then IDLE.
- Assert reset_n low while lcd_en=1 during a frame -> lcd_en=0 and busy=1 in the same cycle (asynchronous). After release, the full init sequence repeats from POWERUP.
- Across all tests, a checker requires lcd_data/lcd_rs stable whenever lcd_en=1 or falling, lcd_rw always 0, and lcd_on/lcd_blon always 1.

Source files
------------

// File: rtl/lcd_hex_display.sv
// lcd_hex_display
//
// Drives an HD44780-compatible 16x2 character LCD in 8-bit, write-only mode.
// After a power-up delay it issues the init command sequence. It then shows
// the 32-bit display_value as eight upper-case hex ASCII characters at line 1,
// columns 0-7. The display is re-rendered only when display_value differs from
// the value shown by the last frame. All LCD timing comes from cycle counters;
// the busy flag is never read.
//
// Ports:
//   clk           system clock (same domain as display_value)
//   reset_n       asynchronous active-low reset, synchronous release expected
//   display_value value to show
//   lcd_data      LCD DB7..DB0
//   lcd_rs        0 = command, 1 = data
//   lcd_rw        always 0 (write)
//   lcd_en        LCD enable strobe
//   lcd_on        LCD power, constant 1
//   lcd_blon      backlight, constant 1
//   busy          high during init or while a frame is being written
module lcd_hex_display #(
  parameter int unsigned POWERUP_CYCLES    = 750000,
  parameter int unsigned EN_PULSE_CYCLES   = 25,
  parameter int unsigned CMD_WAIT_CYCLES   = 2500,
  parameter int unsigned CLEAR_WAIT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] display_value,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        lcd_on,
  output logic        lcd_blon,
  output logic        busy
);

  typedef enum logic [1:0] {
    POWERUP,
    INIT,
    FRAME,
    IDLE
  } state_t;

  // One LCD write: SETUP (1 cycle) -> PULSE -> WAIT.
  typedef enum logic [1:0] {
    W_SETUP,
    W_PULSE,
    W_WAIT
  } wphase_t;

  localparam logic [3:0] INIT_LAST  = 4'd6;
  localparam logic [3:0] FRAME_LAST = 4'd8;

  state_t      state, state_d;
  wphase_t     wph, wph_d;
  logic [3:0]  idx, idx_d;
  logic [31:0] cnt, cnt_d;
  logic [31:0] shadow, shadow_d;
  logic [7:0]  data_d;
  logic        rs_d;

  logic [31:0] wait_len;
  logic        in_write;
  logic        load_write;
  logic [7:0]  next_byte;
  logic        next_rs;
  logic [3:0]  nibble;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) begin
      hex_ascii = 8'h30 + {4'h0, n};
    end else begin
      hex_ascii = 8'h37 + {4'h0, n};
    end
  endfunction

  assign lcd_rw   = 1'b0;
  assign lcd_on   = 1'b1;
  assign lcd_blon = 1'b1;
  assign busy     = (state != IDLE);
  assign in_write = (state == INIT) || (state == FRAME);

  // Combinational enable so that an asynchronous reset drops it at once.
  assign lcd_en = in_write && (wph == W_PULSE);

  // The clear command needs the long post-write wait; the held lcd_data/lcd_rs
  // identify the write currently in its WAIT phase.
  assign wait_len = (!lcd_rs && (lcd_data == 8'h01)) ? CLEAR_WAIT_CYCLES
                                                     : CMD_WAIT_CYCLES;

  // Sequencer: top-level state plus write sub-phase.
  always_comb begin
    state_d  = state;
    wph_d    = wph;
    idx_d    = idx;
    cnt_d    = cnt;
    shadow_d = shadow;

    unique case (state)
      POWERUP: begin
        if (cnt == POWERUP_CYCLES - 1) begin
          state_d = INIT;
          idx_d   = '0;
          wph_d   = W_SETUP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 32'd1;
        end
      end

      INIT, FRAME: begin
        // The frame's first cycle is the SETUP of its 0x80 write.
        if ((state == FRAME) && (wph == W_SETUP) && (idx == 4'd0)) begin
          shadow_d = display_value;
        end
        unique case (wph)
          W_SETUP: begin
            wph_d = W_PULSE;
            cnt_d = '0;
          end
          W_PULSE: begin
            if (cnt == EN_PULSE_CYCLES - 1) begin
              wph_d = W_WAIT;
              cnt_d = '0;
            end else begin
              cnt_d = cnt + 32'd1;
            end
          end
          default: begin
            if (cnt == wait_len - 1) begin
              cnt_d = '0;
              wph_d = W_SETUP;
              if ((state == INIT) && (idx == INIT_LAST)) begin
                state_d = FRAME;
                idx_d   = '0;
              end else if ((state == FRAME) && (idx == FRAME_LAST)) begin
                state_d = IDLE;
                idx_d   = '0;
              end else begin
                idx_d = idx + 4'd1;
              end
            end else begin
              cnt_d = cnt + 32'd1;
            end
          end
        endcase
      end

      default: begin
        wph_d = W_SETUP;
        cnt_d = '0;
        if (display_value != shadow) begin
          state_d = FRAME;
          idx_d   = '0;
        end
      end
    endcase
  end

  // Byte/RS for the write about to enter SETUP. Data writes never start in the
  // cycle that latches shadow, so the registered shadow is always current.
  always_comb begin
    next_byte = 8'h00;
    next_rs   = 1'b0;
    nibble    = '0;
    if (state_d == INIT) begin
      unique case (idx_d)
        4'd0, 4'd1, 4'd2, 4'd3: next_byte = 8'h38;
        4'd4:                   next_byte = 8'h0C;
        4'd5:                   next_byte = 8'h01;
        default:                next_byte = 8'h06;
      endcase
    end else if (idx_d == 4'd0) begin
      next_byte = 8'h80;
    end else begin
      unique case (idx_d)
        4'd1:    nibble = shadow[31:28];
        4'd2:    nibble = shadow[27:24];
        4'd3:    nibble = shadow[23:20];
        4'd4:    nibble = shadow[19:16];
        4'd5:    nibble = shadow[15:12];
        4'd6:    nibble = shadow[11:8];
        4'd7:    nibble = shadow[7:4];
        default: nibble = shadow[3:0];
      endcase
      next_byte = hex_ascii(nibble);
      next_rs   = 1'b1;
    end
  end

  // Bus lines change only on entry to SETUP and then hold through WAIT and IDLE.
  assign load_write = (wph_d == W_SETUP) &&
                      ((state_d == INIT) || (state_d == FRAME)) &&
                      ((wph != W_SETUP) || (state != state_d));

  always_comb begin
    data_d = lcd_data;
    rs_d   = lcd_rs;
    if (load_write) begin
      data_d = next_byte;
      rs_d   = next_rs;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= POWERUP;
      wph      <= W_SETUP;
      idx      <= '0;
      cnt      <= '0;
      shadow   <= '0;
      lcd_data <= '0;
      lcd_rs   <= 1'b0;
    end else begin
      state    <= state_d;
      wph      <= wph_d;
      idx      <= idx_d;
      cnt      <= cnt_d;
      shadow   <= shadow_d;
      lcd_data <= data_d;
      lcd_rs   <= rs_d;
    end
  end

endmodule

// File: tb/tb_lcd_hex_display.sv
// tb_lcd_hex_display
//
// Directed bench for lcd_hex_display with short timing parameters
// (POWERUP=10, EN=2, CMD_WAIT=4, CLEAR_WAIT=8). Expected LCD writes
// ({rs, data}) are queued as stimulus is applied and popped on each lcd_en
// rising edge seen by the bus monitor.
module tb_lcd_hex_display;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] display_value;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon, busy;

  always #5 clk = ~clk;

  lcd_hex_display #(
    .POWERUP_CYCLES   (10),
    .EN_PULSE_CYCLES  (2),
    .CMD_WAIT_CYCLES  (4),
    .CLEAR_WAIT_CYCLES(8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .display_value(display_value),
    .lcd_data     (lcd_data),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_en       (lcd_en),
    .lcd_on       (lcd_on),
    .lcd_blon     (lcd_blon),
    .busy         (busy)
  );

  int         checks = 0;
  int         errors = 0;
  int         en_rises = 0;
  logic [8:0] exp_q[$];
  string      hex_digits = "0123456789ABCDEF";

  // Monitor state
  logic       prev_en = 1'b0;
  logic [8:0] prev_word = '0;
  logic [8:0] last_word = '0;
  logic       have_prev = 1'b0;
  int         en_len = 0;
  int         gap = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_init();
    logic [7:0] cmds [7] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    foreach (cmds[i]) exp_q.push_back({1'b0, cmds[i]});
  endtask

  task automatic push_frame(input logic [31:0] v);
    logic [3:0] n;
    exp_q.push_back(9'h080);
    for (int i = 7; i >= 0; i--) begin
      n = v[i*4 +: 4];
      exp_q.push_back({1'b1, hex_digits.getc(int'(n))});
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < 3000);
    if (n >= 3000) check("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_rises(input int target);
    int n = 0;
    while (en_rises < target && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("rise_timeout", {31'b0, (en_rises >= target)}, 32'd1);
  endtask

  // Bus monitor: pops/compares writes, checks pulse width, inter-write gap,
  // bus stability while enabled or falling, and the constant outputs.
  always @(negedge clk) begin
    logic [8:0] word;
    logic [8:0] exp;
    word = {lcd_rs, lcd_data};
    check("lcd_rw", {31'b0, lcd_rw}, 32'd0);
    check("lcd_on", {31'b0, lcd_on}, 32'd1);
    check("lcd_blon", {31'b0, lcd_blon}, 32'd1);
    if (!reset_n) begin
      prev_en   = 1'b0;
      have_prev = 1'b0;
      en_len    = 0;
      gap       = 0;
    end else begin
      if (lcd_en && !prev_en) begin
        en_rises++;
        en_len = 1;
        check("expected_write_available", {31'b0, (exp_q.size() > 0)}, 32'd1);
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          check("write_word", {23'b0, word}, {23'b0, exp});
          if (have_prev && exp != 9'h080)
            check("write_gap", gap, (last_word == 9'h001) ? 9 : 5);
        end
        last_word = word;
      end else if (lcd_en) begin
        en_len++;
        check("bus_stable_high", {23'b0, word}, {23'b0, prev_word});
      end
      if (!lcd_en && prev_en) begin
        check("bus_stable_fall", {23'b0, word}, {23'b0, prev_word});
        check("en_width", en_len, 2);
        have_prev = 1'b1;
        gap = 1;
      end else if (!lcd_en) begin
        gap++;
      end
      prev_en   = lcd_en;
      prev_word = word;
    end
  end

  initial begin
    int n;
    int base;

    // Reset state and first init + frame of zeros
    reset_n       = 1'b0;
    display_value = 32'h0000_0000;
    repeat (3) @(negedge clk);
    check("reset_en", {31'b0, lcd_en}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd1);
    check("reset_data", {24'b0, lcd_data}, 32'd0);
    check("reset_rs", {31'b0, lcd_rs}, 32'd0);
    push_init();
    push_frame(32'h0000_0000);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("powerup_en_low", {31'b0, lcd_en}, 32'd0);
      check("powerup_busy", {31'b0, busy}, 32'd1);
    end
    wait_idle(n);
    check("init_plus_frame_len", n, 116);
    check("queue_drained_init", exp_q.size(), 0);

    // New value in IDLE triggers exactly one frame
    @(negedge clk);
    display_value = 32'h1234_ABCF;
    push_frame(32'h1234_ABCF);
    @(negedge clk);
    check("busy_rise", {31'b0, busy}, 32'd1);
    wait_idle(n);
    check("frame_len", n, 63);
    check("queue_drained_frame", exp_q.size(), 0);

    // Stable value: no writes, busy stays low
    base = en_rises;
    repeat (500) begin
      @(negedge clk);
      check("idle_busy_low", {31'b0, busy}, 32'd0);
    end
    check("idle_no_pulses", en_rises, base);

    // Value change during a frame: that frame completes, then another follows
    @(negedge clk);
    display_value = 32'h0000_0000;
    push_frame(32'h0000_0000);
    push_frame(32'hFFFF_FFFF);
    base = en_rises;
    wait_rises(base + 4);
    @(negedge clk);
    display_value = 32'hFFFF_FFFF;
    wait_idle(n);
    check("second_frame_pending", exp_q.size(), 9);
    @(negedge clk);
    check("refire_busy", {31'b0, busy}, 32'd1);
    wait_idle(n);
    check("refire_frame_len", n, 63);
    check("queue_drained_refire", exp_q.size(), 0);

    // Asynchronous reset while lcd_en is high, then full restart
    @(negedge clk);
    display_value = 32'h0000_0005;
    push_frame(32'h0000_0005);
    base = en_rises;
    wait_rises(base + 2);
    #2;
    check("pre_reset_en_high", {31'b0, lcd_en}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_reset_en", {31'b0, lcd_en}, 32'd0);
    check("async_reset_busy", {31'b0, busy}, 32'd1);
    exp_q.delete();
    push_init();
    push_frame(32'h0000_0005);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("repowerup_en_low", {31'b0, lcd_en}, 32'd0);
    end
    wait_idle(n);
    check("reinit_plus_frame_len", n, 116);
    check("queue_drained_reinit", exp_q.size(), 0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
